// File: rtl/sram_weightmem_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_weightmem_reader
// Brief    : Streams a run of consecutive words out of one weight-bank SRAM
//            onto a valid/ready stream. A credit check on issue keeps the
//            small output FIFO from overflowing across the one-cycle read
//            latency.
// Revision : 1.0 - initial release
// ============================================================================
module sram_weightmem_reader #(
  parameter int NUM_WORDS  = 256,
  parameter int DATA_WIDTH = 40,
  parameter int FIFO_DEPTH = 2,
  parameter int AW         = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AW-1:0]         base_addr_i,
  input  logic [AW:0]           len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [AW-1:0] c_LAST_ADDR = AW'(NUM_WORDS - 1);
  localparam logic [PW-1:0] c_LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   c_DEPTH     = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]            r_state;
  logic [AW-1:0]         r_addr;       // next address to issue
  logic [AW-1:0]         r_addr_hold;  // last issued address, shown while idle
  logic [AW:0]           r_remaining;
  logic [AW:0]           r_outstanding;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CW:0]           w_level;
  logic [AW-1:0]         w_next_addr;

  // Occupancy after this cycle counts buffered words plus the read in flight;
  // a new read is only issued if a slot is guaranteed for its data.
  assign w_pop       = (r_count != '0) && ready_i;
  assign w_push      = r_inflight;
  assign w_level     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue     = (r_state == c_ISSUE) && (r_remaining != '0) && (w_level < c_DEPTH);
  assign w_next_addr = (r_addr == c_LAST_ADDR) ? '0 : r_addr + AW'(1);

  assign mem_req_o  = w_issue;
  assign mem_we_o   = 1'b0;
  assign mem_addr_o = w_issue ? r_addr : r_addr_hold;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign valid_o    = (r_count != '0);
  assign data_o     = r_mem[r_rd_ptr];

  // Job sequencer: start capture, read issue, and completion on the final pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= c_IDLE;
      r_addr        <= '0;
      r_addr_hold   <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_inflight    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        c_IDLE: begin
          if (start_i) begin
            r_addr        <= base_addr_i;
            r_remaining   <= len_i;
            r_outstanding <= len_i;
            if (len_i != '0) begin
              r_state <= c_ISSUE;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          if (w_issue) begin
            r_addr      <= w_next_addr;
            r_addr_hold <= r_addr;
            r_remaining <= r_remaining - (AW + 1)'(1);
            if (r_remaining == (AW + 1)'(1)) begin
              r_state <= c_DRAIN;
            end
          end
          if (w_pop) begin
            r_outstanding <= r_outstanding - (AW + 1)'(1);
            if (r_outstanding == (AW + 1)'(1)) begin
              r_state <= c_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output FIFO: capture read data exactly in its valid cycle, pop on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= mem_rdata_i;
        r_wr_ptr        <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_weightmem_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_weightmem_reader
// Brief    : Directed self-checking bench for sram_weightmem_reader with a
//            16-word bank model holding word[a] = a.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_weightmem_reader;

  localparam int NW = 16;
  localparam int AW = 4;
  localparam int DW = 40;
  localparam logic [DW-1:0] c_POISON = 40'hDE_ADBE_EF55;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   len_i = '0;
  logic          busy_o, done_o, mem_req_o, mem_we_o, valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i = c_POISON;
  logic [DW-1:0] data_o;
  logic          ready_i = 1'b1;

  int tests = 0;
  int fails = 0;

  sram_weightmem_reader #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Bank model: one-cycle read latency, poison data when not reading.
  always @(posedge clk_i) begin
    if (mem_req_o === 1'b1) mem_rdata_i <= DW'(mem_addr_o);
    else                    mem_rdata_i <= c_POISON;
  end

  // Monitor, sampled mid-cycle on the falling edge.
  int            cyc = 0;
  logic [AW-1:0] req_addr[$];
  int            req_cyc[$];
  logic [DW-1:0] pop_data[$];
  int            pop_cyc[$];
  int            done_cyc[$];
  int            we_err, valid_cnt, max_occ, issued_before_pop;
  bit            last_req, prev_busy, busy_at_done, busy_before_done;

  always @(negedge clk_i) begin
    int occ;
    cyc++;
    occ = req_addr.size() - int'(last_req) - pop_data.size();
    if (occ > max_occ) max_occ = occ;
    if (mem_we_o !== 1'b0) we_err++;
    if (valid_o === 1'b1) valid_cnt++;
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      if (pop_data.size() == 0) issued_before_pop = req_addr.size();
      pop_data.push_back(data_o);
      pop_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) begin
      done_cyc.push_back(cyc);
      busy_at_done     = busy_o;
      busy_before_done = prev_busy;
    end
    last_req = (mem_req_o === 1'b1);
    if (last_req) begin
      req_addr.push_back(mem_addr_o);
      req_cyc.push_back(cyc);
    end
    prev_busy = busy_o;
  end

  task automatic clear_mon();
    req_addr.delete(); req_cyc.delete(); pop_data.delete(); pop_cyc.delete();
    done_cyc.delete();
    we_err = 0; valid_cnt = 0; max_occ = 0; issued_before_pop = 0;
    last_req = 1'b0; busy_at_done = 1'b0; busy_before_done = 1'b0;
  endtask

  // Pulse start for one cycle; c0 is the monitor index of that cycle.
  task automatic start_job(input int base, input int len, output int c0);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = AW'(base); len_i = (AW + 1)'(len);
    @(negedge clk_i); #1;
    c0 = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) @(negedge clk_i);
    tests++;
    if (done_cyc.size() == 0) begin
      fails++; $display("FAIL done_timeout: got no done_o within %0d cycles", budget);
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0;
    @(negedge clk_i); #1;
    tests++; if (busy_o !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    tests++; if (done_o !== 1'b0)    begin fails++; $display("FAIL rst_done: got %b want 0", done_o); end
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    tests++; if (mem_we_o !== 1'b0)  begin fails++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
    tests++; if (valid_o !== 1'b0)   begin fails++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    tests++; if (mem_addr_o !== '0)  begin fails++; $display("FAIL rst_addr: got %0d want 0", mem_addr_o); end
    tests++; if (data_o !== '0)      begin fails++; $display("FAIL rst_data: got %0h want 0", data_o); end
  endtask

  task automatic test_basic();
    int c0;
    ready_i = 1'b1; clear_mon();
    start_job(5, 4, c0);
    wait_done(30);
    tests++; if (pop_data.size() != 4) begin fails++; $display("FAIL basic_count: got %0d want 4", pop_data.size()); end
    for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
      tests++; if (pop_data[i] !== DW'(5 + i)) begin fails++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, pop_data[i], 5 + i); end
      tests++; if (pop_cyc[i] != c0 + 3 + i) begin fails++; $display("FAIL basic_vcyc[%0d]: got %0d want %0d", i, pop_cyc[i] - c0, 3 + i); end
    end
    tests++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 7) begin fails++; $display("FAIL basic_done: got n=%0d rel=%0d want n=1 rel=7", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1); end
    tests++; if (req_addr.size() != 4) begin fails++; $display("FAIL basic_reqs: got %0d want 4", req_addr.size()); end
    tests++; if (req_cyc.size() > 0 && req_cyc[0] != c0 + 1) begin fails++; $display("FAIL basic_req_lat: got %0d want 1", req_cyc[0] - c0); end
    tests++; if (we_err != 0) begin fails++; $display("FAIL basic_we: got %0d writes want 0", we_err); end
  endtask

  task automatic test_wrap();
    int c0;
    int exp_a[4] = '{14, 15, 0, 1};
    ready_i = 1'b1; clear_mon();
    start_job(14, 4, c0);
    wait_done(30);
    tests++; if (req_addr.size() != 4) begin fails++; $display("FAIL wrap_reqs: got %0d want 4", req_addr.size()); end
    for (int i = 0; i < 4 && i < req_addr.size(); i++) begin
      tests++; if (req_addr[i] !== AW'(exp_a[i])) begin fails++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, req_addr[i], exp_a[i]); end
    end
    for (int i = 0; i < 4 && i < pop_data.size(); i++) begin
      tests++; if (pop_data[i] !== DW'(exp_a[i])) begin fails++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, pop_data[i], exp_a[i]); end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    ready_i = 1'b0; clear_mon();
    start_job(3, 8, c0);
    for (int k = 0; k < 200 && done_cyc.size() == 0; k++) begin
      @(posedge clk_i); #1;
      ready_i = (k % 3 == 2);
    end
    tests++; if (done_cyc.size() == 0) begin fails++; $display("FAIL bp_timeout: got no done_o want done"); end
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    tests++; if (pop_data.size() != 8) begin fails++; $display("FAIL bp_count: got %0d want 8", pop_data.size()); end
    for (int i = 0; i < 8 && i < pop_data.size(); i++) begin
      tests++; if (pop_data[i] !== DW'(3 + i)) begin fails++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, pop_data[i], 3 + i); end
    end
    tests++; if (max_occ > 2) begin fails++; $display("FAIL bp_occupancy: got %0d want <=2", max_occ); end
    tests++; if (issued_before_pop > 3) begin fails++; $display("FAIL bp_early_reads: got %0d want <=3", issued_before_pop); end
    tests++; if (done_cyc.size() != 1) begin fails++; $display("FAIL bp_done_n: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_zero_and_ignore();
    int c0;
    ready_i = 1'b1; clear_mon();
    start_job(2, 0, c0);
    repeat (4) @(posedge clk_i);
    #1;
    tests++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + 1) begin fails++; $display("FAIL zero_done: got n=%0d want n=1 rel=1", done_cyc.size()); end
    tests++; if (req_addr.size() != 0) begin fails++; $display("FAIL zero_reqs: got %0d want 0", req_addr.size()); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b want 0", busy_o); end
    clear_mon();
    start_job(0, 6, c0);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = 4'd10; len_i = 5'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(50);
    tests++; if (pop_data.size() != 6) begin fails++; $display("FAIL ign_count: got %0d want 6", pop_data.size()); end
    for (int i = 0; i < 6 && i < pop_data.size(); i++) begin
      tests++; if (pop_data[i] !== DW'(i)) begin fails++; $display("FAIL ign_data[%0d]: got %0d want %0d", i, pop_data[i], i); end
    end
    tests++; if (done_cyc.size() != 1) begin fails++; $display("FAIL ign_done_n: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_reset_midjob();
    int c0;
    ready_i = 1'b1; clear_mon();
    start_job(4, 5, c0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_mon();
    repeat (6) @(posedge clk_i);
    #1;
    tests++; if (valid_cnt != 0) begin fails++; $display("FAIL rmj_valid: got %0d cycles want 0", valid_cnt); end
    tests++; if (done_cyc.size() != 0) begin fails++; $display("FAIL rmj_done: got %0d want 0", done_cyc.size()); end
    tests++; if (req_addr.size() != 0) begin fails++; $display("FAIL rmj_reqs: got %0d want 0", req_addr.size()); end
    clear_mon();
    start_job(7, 2, c0);
    wait_done(30);
    tests++; if (pop_data.size() != 2 || pop_cyc[0] != c0 + 3) begin fails++; $display("FAIL rmj_latency: got n=%0d rel=%0d want n=2 rel=3", pop_data.size(), (pop_cyc.size() > 0) ? pop_cyc[0] - c0 : -1); end
    tests++; if (pop_data.size() == 2 && (pop_data[0] !== DW'(7) || pop_data[1] !== DW'(8))) begin fails++; $display("FAIL rmj_data: got %0d,%0d want 7,8", pop_data[0], pop_data[1]); end
  endtask

  task automatic test_full_depth();
    int c0;
    ready_i = 1'b1; clear_mon();
    start_job(0, NW, c0);
    wait_done(60);
    tests++; if (pop_data.size() != NW) begin fails++; $display("FAIL full_count: got %0d want %0d", pop_data.size(), NW); end
    for (int i = 0; i < NW && i < pop_data.size(); i++) begin
      tests++; if (pop_data[i] !== DW'(i)) begin fails++; $display("FAIL full_data[%0d]: got %0d want %0d", i, pop_data[i], i); end
    end
    tests++; if (pop_cyc.size() == NW && pop_cyc[NW-1] != c0 + NW + 2) begin fails++; $display("FAIL full_last: got %0d want %0d", pop_cyc[NW-1] - c0, NW + 2); end
    tests++; if (done_cyc.size() != 1 || done_cyc[0] != c0 + NW + 3) begin fails++; $display("FAIL full_done: got n=%0d want n=1 rel=%0d", done_cyc.size(), NW + 3); end
    tests++; if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin fails++; $display("FAIL full_busy: got at=%b before=%b want 0,1", busy_at_done, busy_before_done); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignore();
    test_reset_midjob();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
